// File: rtl/wb_bypass_if.sv
// Execute-result / load / decode-operand / write-port bundle for the write-back
// bypass stage. The slave side is the bypass block, the master side is its environment.
interface wb_bypass_if #(parameter int AW = 3, parameter int DW = 8);
   logic          in_valid, in_ready;
   logic [AW-1:0] in_dstE, in_dstM;
   logic [DW-1:0] in_valE;
   logic          in_memrd;
   logic [DW-1:0] mem_data;
   logic          mem_ack;
   logic [AW-1:0] srcA, srcB;
   logic [DW-1:0] rf_A, rf_B;
   logic [DW-1:0] opA, opB;
   logic          stall;
   logic [AW-1:0] dstM, dstE;
   logic [DW-1:0] M, E;

   modport slave (
      input  in_valid, in_dstE, in_valE, in_dstM, in_memrd, mem_data, mem_ack,
             srcA, srcB, rf_A, rf_B,
      output in_ready, opA, opB, stall, dstM, dstE, M, E
   );
   modport master (
      output in_valid, in_dstE, in_valE, in_dstM, in_memrd, mem_data, mem_ack,
             srcA, srcB, rf_A, rf_B,
      input  in_ready, opA, opB, stall, dstM, dstE, M, E
   );
endinterface

// File: rtl/wb_bypass.sv
// Two-slot MEM/WB pipeline tail with register write port and per-operand
// forwarding network; stalls decode on a use of a still-outstanding load.
module wb_bypass_fwd #(parameter int AW = 3, parameter int DW = 8) (
   input  logic [AW-1:0] src,
   input  logic [DW-1:0] rf,
   input  logic          mem_vld,
   input  logic          mem_memrd,
   input  logic          mem_ack,
   input  logic [AW-1:0] mem_dstM,
   input  logic [AW-1:0] mem_dstE,
   input  logic [DW-1:0] mem_valE,
   input  logic [DW-1:0] mem_data,
   input  logic          wb_vld,
   input  logic [AW-1:0] wb_dstM,
   input  logic [AW-1:0] wb_dstE,
   input  logic [DW-1:0] wb_M,
   input  logic [DW-1:0] wb_E,
   output logic [DW-1:0] op,
   output logic          stall
);
   // src != 0 is checked first, so a zero destination can never match below
   always_comb begin
      op    = rf;
      stall = 1'b0;
      if (src == '0)                                             op = '0;
      else if (mem_vld && mem_memrd && mem_ack && mem_dstM == src) op = mem_data;
      else if (mem_vld && mem_dstE == src)                         op = mem_valE;
      else if (wb_vld && wb_dstM == src)                           op = wb_M;
      else if (wb_vld && wb_dstE == src)                           op = wb_E;
      if (src != '0 && mem_vld && mem_memrd && !mem_ack && mem_dstM == src)
         stall = 1'b1;
   end
endmodule

module wb_bypass #(parameter int AW = 3, parameter int DW = 8) (
   input logic     clk,
   input logic     rst,
   wb_bypass_if.slave bus
);
   localparam int NUM_OPS = 2;

   typedef struct packed {
      logic          vld;
      logic [AW-1:0] dstE;
      logic [DW-1:0] valE;
      logic [AW-1:0] dstM;
      logic          memrd;
   } mem_slot_t;

   typedef struct packed {
      logic          vld;
      logic [AW-1:0] dstE;
      logic [DW-1:0] E;
      logic [AW-1:0] dstM;
      logic [DW-1:0] M;
   } wb_slot_t;

   mem_slot_t mem_q;
   wb_slot_t  wb_q;
   logic      mem_done, xfer;

   assign mem_done     = mem_q.vld && (!mem_q.memrd || bus.mem_ack);
   assign bus.in_ready = !mem_q.vld || mem_done;
   assign xfer         = bus.in_valid && bus.in_ready;

   // Empty slots are zeroed so the write port and match logic see no stale state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         if (xfer)
            mem_q <= '{vld: 1'b1, dstE: bus.in_dstE, valE: bus.in_valE,
                       dstM: (bus.in_memrd ? bus.in_dstM : {AW{1'b0}}),
                       memrd: bus.in_memrd};
         else if (mem_done)
            mem_q <= '0;
         if (mem_done)
            wb_q <= '{vld: 1'b1, dstE: mem_q.dstE, E: mem_q.valE, dstM: mem_q.dstM,
                      M: (mem_q.memrd ? bus.mem_data : {DW{1'b0}})};
         else
            wb_q <= '0;
      end
   end

   assign bus.dstM = wb_q.dstM;
   assign bus.dstE = wb_q.dstE;
   assign bus.M    = wb_q.M;
   assign bus.E    = wb_q.E;

   logic [NUM_OPS-1:0][AW-1:0] src;
   logic [NUM_OPS-1:0][DW-1:0] rf, op;
   logic [NUM_OPS-1:0]         stall_v;

   assign src       = {bus.srcB, bus.srcA};
   assign rf        = {bus.rf_B, bus.rf_A};
   assign bus.opA   = op[0];
   assign bus.opB   = op[1];
   assign bus.stall = |stall_v;

   for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
      wb_bypass_fwd #(.AW(AW), .DW(DW)) u_fwd (
         .src      (src[g]),
         .rf       (rf[g]),
         .mem_vld  (mem_q.vld),
         .mem_memrd(mem_q.memrd),
         .mem_ack  (bus.mem_ack),
         .mem_dstM (mem_q.dstM),
         .mem_dstE (mem_q.dstE),
         .mem_valE (mem_q.valE),
         .mem_data (bus.mem_data),
         .wb_vld   (wb_q.vld),
         .wb_dstM  (wb_q.dstM),
         .wb_dstE  (wb_q.dstE),
         .wb_M     (wb_q.M),
         .wb_E     (wb_q.E),
         .op       (op[g]),
         .stall    (stall_v[g])
      );
   end
endmodule

// File: tb/tb_wb_bypass.sv
// Directed bench for wb_bypass: inputs change 1 time unit after posedge,
// outputs are sampled on negedge. Cycle k is the interval ending at edge k.
module tb_wb_bypass;
   logic clk, rst;
   int   total, bad;

   wb_bypass_if bus ();

   wb_bypass dut (.clk(clk), .rst(rst), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic idle;
      bus.in_valid = 0; bus.in_dstE = 0; bus.in_valE = 0; bus.in_dstM = 0; bus.in_memrd = 0;
      bus.mem_data = 0; bus.mem_ack = 0;
      bus.srcA = 0; bus.srcB = 0; bus.rf_A = 0; bus.rf_B = 0;
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic drain;
      idle; tick; tick; tick;
   endtask

   task automatic test_reset;
      rst = 1'b1; idle;
      #2;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", bus.stall); end
      total++; if ({bus.dstM, bus.dstE} !== 6'd0) begin bad++; $display("FAIL rst_dst got=%h/%h exp=0/0", bus.dstM, bus.dstE); end
      total++; if ({bus.M, bus.E} !== 16'd0) begin bad++; $display("FAIL rst_data got=%h/%h exp=0/0", bus.M, bus.E); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_alu;
      drain;
      bus.in_valid = 1; bus.in_dstE = 3'd3; bus.in_valE = 8'h5A; bus.in_dstM = 3'd7; bus.in_memrd = 0;
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL alu_ready_c0 got=%b exp=1", bus.in_ready); end
      tick; idle; bus.srcA = 3'd3;
      @(negedge clk);
      total++; if (bus.opA !== 8'h5A) begin bad++; $display("FAIL alu_opA_c1 got=%h exp=5a", bus.opA); end
      total++; if (bus.dstE !== 3'd0) begin bad++; $display("FAIL alu_dstE_c1 got=%0d exp=0", bus.dstE); end
      tick;
      @(negedge clk);
      total++; if (bus.dstE !== 3'd3 || bus.E !== 8'h5A) begin bad++; $display("FAIL alu_wr_c2 got=%0d/%h exp=3/5a", bus.dstE, bus.E); end
      total++; if (bus.dstM !== 3'd0 || bus.M !== 8'h00) begin bad++; $display("FAIL alu_nodstM_c2 got=%0d/%h exp=0/00", bus.dstM, bus.M); end
      total++; if (bus.opA !== 8'h5A) begin bad++; $display("FAIL alu_opA_c2 got=%h exp=5a", bus.opA); end
      tick; bus.rf_A = 8'h33;
      @(negedge clk);
      total++; if (bus.dstE !== 3'd0 || bus.E !== 8'h00) begin bad++; $display("FAIL alu_clear_c3 got=%0d/%h exp=0/00", bus.dstE, bus.E); end
      total++; if (bus.opA !== 8'h33) begin bad++; $display("FAIL alu_rf_c3 got=%h exp=33", bus.opA); end
   endtask

   task automatic test_load;
      drain;
      bus.in_valid = 1; bus.in_dstM = 3'd4; bus.in_memrd = 1;
      tick;
      bus.in_dstM = 0; bus.in_memrd = 0; bus.in_dstE = 3'd6; bus.in_valE = 8'h66;
      bus.srcB = 3'd4; bus.rf_B = 8'h00;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL ld_stall_c%0d got=%b exp=1", c, bus.stall); end
         total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL ld_ready_c%0d got=%b exp=0", c, bus.in_ready); end
         tick;
      end
      bus.mem_ack = 1; bus.mem_data = 8'hC3;
      @(negedge clk);
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL ld_stall_c3 got=%b exp=0", bus.stall); end
      total++; if (bus.opB !== 8'hC3) begin bad++; $display("FAIL ld_opB_c3 got=%h exp=c3", bus.opB); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ld_ready_c3 got=%b exp=1", bus.in_ready); end
      tick;
      bus.in_valid = 0; bus.mem_ack = 0; bus.mem_data = 8'h5F; bus.srcA = 3'd6;
      @(negedge clk);
      total++; if (bus.dstM !== 3'd4 || bus.M !== 8'hC3) begin bad++; $display("FAIL ld_wr_c4 got=%0d/%h exp=4/c3", bus.dstM, bus.M); end
      total++; if (bus.opB !== 8'hC3) begin bad++; $display("FAIL ld_opB_wb_c4 got=%h exp=c3", bus.opB); end
      total++; if (bus.opA !== 8'h66) begin bad++; $display("FAIL ld_refill_opA_c4 got=%h exp=66", bus.opA); end
      tick;
      @(negedge clk);
      total++; if (bus.dstE !== 3'd6 || bus.E !== 8'h66 || bus.dstM !== 3'd0) begin bad++; $display("FAIL ld_refill_wr_c5 got=%0d/%h/%0d exp=6/66/0", bus.dstE, bus.E, bus.dstM); end
   endtask

   task automatic test_pop;
      drain;
      bus.in_valid = 1; bus.in_dstM = 3'd5; bus.in_dstE = 3'd5; bus.in_valE = 8'h11; bus.in_memrd = 1;
      tick;
      bus.in_valid = 0; bus.mem_ack = 1; bus.mem_data = 8'h22; bus.srcA = 3'd5; bus.rf_A = 8'hAA;
      @(negedge clk);
      total++; if (bus.opA !== 8'h22 || bus.stall !== 1'b0) begin bad++; $display("FAIL pop_mem_opA got=%h/%b exp=22/0", bus.opA, bus.stall); end
      tick;
      bus.mem_ack = 0; bus.mem_data = 8'h99;
      @(negedge clk);
      total++; if (bus.opA !== 8'h22) begin bad++; $display("FAIL pop_wb_opA got=%h exp=22", bus.opA); end
      total++; if (bus.dstM !== 3'd5 || bus.M !== 8'h22) begin bad++; $display("FAIL pop_wrM got=%0d/%h exp=5/22", bus.dstM, bus.M); end
      total++; if (bus.dstE !== 3'd5 || bus.E !== 8'h11) begin bad++; $display("FAIL pop_wrE got=%0d/%h exp=5/11", bus.dstE, bus.E); end
   endtask

   task automatic test_bypass_prio;
      drain;
      bus.in_valid = 1; bus.in_dstE = 3'd0; bus.in_valE = 8'hEE;
      tick;
      bus.in_valid = 0; bus.srcA = 3'd0; bus.rf_A = 8'hFF;
      @(negedge clk);
      total++; if (bus.opA !== 8'h00) begin bad++; $display("FAIL zero_src_opA got=%h exp=00", bus.opA); end
      drain;
      bus.in_valid = 1; bus.in_dstE = 3'd2; bus.in_valE = 8'h01;
      tick;
      bus.in_valE = 8'h02;
      tick;
      bus.in_valid = 0; bus.srcA = 3'd2; bus.rf_A = 8'h77;
      @(negedge clk);
      total++; if (bus.opA !== 8'h02) begin bad++; $display("FAIL b2b_mem_beats_wb got=%h exp=02", bus.opA); end
      total++; if (bus.dstE !== 3'd2 || bus.E !== 8'h01) begin bad++; $display("FAIL b2b_wr1 got=%0d/%h exp=2/01", bus.dstE, bus.E); end
      tick;
      @(negedge clk);
      total++; if (bus.opA !== 8'h02 || bus.E !== 8'h02) begin bad++; $display("FAIL b2b_wr2 got=%h/%h exp=02/02", bus.opA, bus.E); end
   endtask

   task automatic test_reset_mid;
      drain;
      bus.in_valid = 1; bus.in_dstM = 3'd6; bus.in_memrd = 1;
      tick;
      bus.in_dstM = 3'd7; bus.mem_ack = 1; bus.mem_data = 8'h77;
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rm_ready_drain got=%b exp=1", bus.in_ready); end
      tick;
      bus.in_valid = 0; bus.mem_ack = 0; bus.srcA = 3'd7;
      @(negedge clk);
      total++; if (bus.stall !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL rm_wait got=%b/%b exp=1/0", bus.stall, bus.in_ready); end
      total++; if (bus.dstM !== 3'd6 || bus.M !== 8'h77) begin bad++; $display("FAIL rm_wr6 got=%0d/%h exp=6/77", bus.dstM, bus.M); end
      #1 rst = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b1 || bus.stall !== 1'b0) begin bad++; $display("FAIL rm_async got=%b/%b exp=1/0", bus.in_ready, bus.stall); end
      total++; if (bus.dstM !== 3'd0 || bus.M !== 8'h00) begin bad++; $display("FAIL rm_async_wr got=%0d/%h exp=0/00", bus.dstM, bus.M); end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.mem_ack = 1; bus.mem_data = 8'hAB; bus.srcA = 3'd0;
      bus.in_valid = 1; bus.in_dstE = 3'd1; bus.in_valE = 8'h21; bus.in_dstM = 0; bus.in_memrd = 0;
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rm_first_ready got=%b exp=1", bus.in_ready); end
      tick;
      bus.mem_ack = 0; bus.in_valid = 0; bus.srcA = 3'd1;
      @(negedge clk);
      total++; if (bus.opA !== 8'h21) begin bad++; $display("FAIL rm_first_opA got=%h exp=21", bus.opA); end
      total++; if (bus.dstM !== 3'd0 || bus.M !== 8'h00) begin bad++; $display("FAIL rm_no_ghost got=%0d/%h exp=0/00", bus.dstM, bus.M); end
      tick;
      @(negedge clk);
      total++; if (bus.dstE !== 3'd1 || bus.E !== 8'h21 || bus.dstM !== 3'd0) begin bad++; $display("FAIL rm_first_wr got=%0d/%h/%0d exp=1/21/0", bus.dstE, bus.E, bus.dstM); end
   endtask

   task automatic test_back_to_back;
      logic [2:0] ed;
      logic [7:0] ev;
      drain;
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = (i < 8);
         bus.in_dstE  = 3'((i % 7) + 1);
         bus.in_valE  = 8'(8'h10 + i);
         @(negedge clk);
         if (i < 8) begin
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready_%0d got=%b exp=1", i, bus.in_ready); end
         end
         if (i >= 2) begin
            ed = 3'(((i - 2) % 7) + 1);
            ev = 8'(8'h10 + i - 2);
            total++; if (bus.dstE !== ed || bus.E !== ev) begin bad++; $display("FAIL stream_wr_%0d got=%0d/%h exp=%0d/%h", i, bus.dstE, bus.E, ed, ev); end
         end
         tick;
      end
      idle;
   endtask

   initial begin
      total = 0; bad = 0;
      test_reset;
      test_alu;
      test_load;
      test_pop;
      test_bypass_prio;
      test_reset_mid;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb_bypass.md
WB_BYPASS -- requirements
Module: wb_bypass

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports in_valid input 1, in_ready output 1: execute-result handshake; transfer when both high at posedge.
REQ-004 SHALL have ports in_dstE input 3, in_valE input 8: ALU destination and value.
REQ-005 SHALL have ports in_dstM input 3, in_memrd input 1: memory-load destination; load pending when in_memrd=1.
REQ-006 SHALL have ports mem_data input 8, mem_ack input 1: load data, valid while mem_ack=1.
REQ-007 SHALL have ports srcA input 3, srcB input 3, rf_A input 8, rf_B input 8: decode sources and raw register-file read data.
REQ-008 SHALL have ports opA output 8, opB output 8, stall output 1: forwarded operands; decode hold request.
REQ-009 SHALL have ports dstM output 3, dstE output 3, M output 8, E output 8: register-file write port; address 0 means no write.

Function
REQ-010 SHALL hold two slots: MEM (valid, dstE, valE, dstM, memrd, data) and WB (valid, dstE, E, dstM, M).
REQ-011 SHALL capture in_* into MEM on transfer; SHALL store dstM=0 when in_memrd=0.
REQ-012 SHALL treat MEM as complete when valid and (memrd=0 or mem_ack=1 this cycle); SHALL latch mem_data into the M value on completion.
REQ-013 SHALL drive in_ready = !MEM.valid | MEM complete (combinational); MEM refills on the same edge it drains.
REQ-014 SHALL move a complete MEM entry into WB at posedge; WB SHALL otherwise become invalid (WB always drains in one cycle).
REQ-015 SHALL drive dstM/dstE/M/E from WB registers; when WB invalid, dstM=dstE=0, M=E=0.
REQ-016 Latency: ALU-only result appears on write port exactly 2 cycles after transfer edge; load result 1 cycle after the mem_ack cycle edge.
REQ-017 SHALL ignore mem_ack when MEM is invalid or MEM.memrd=0.
REQ-018 Forwarding per operand X (opX, combinational): srcX=0 -> 0.
REQ-019 Else priority: MEM.dstM match (memrd, mem_ack) -> mem_data; MEM.dstE match -> MEM.valE; WB.dstM match -> WB.M; WB.dstE match -> WB.E; else rf_X.
REQ-020 dstM SHALL outrank dstE within each slot, matching register-file write priority when dstM=dstE.
REQ-021 SHALL assert stall when any srcX≠0 equals MEM.dstM with MEM valid, memrd=1, mem_ack=0; opX value undefined-don't-care while stalled but SHALL not be X.
REQ-022 A match SHALL only count from a valid slot and nonzero destination.

Reset
REQ-023 rst=1 SHALL immediately clear MEM.valid, WB.valid, all stored values to 0; outputs dstM=dstE=0, M=E=0, stall=0, in_ready=1.
REQ-024 A load outstanding at reset SHALL be abandoned; a later mem_ack SHALL have no effect.
REQ-025 After rst deassert, first transfer SHALL be accepted on first posedge with in_valid=1.

Verification
REQ-026 ALU op dstE=3,valE=0x5A at edge 0 -> dstE=3,E=0x5A during cycle 2; srcA=3 in cycle 1 -> opA=0x5A, in cycle 2 -> opA=0x5A.
REQ-027 Load dstM=4, mem_ack at cycle 3 data=0xC3, srcB=4 -> stall=1 cycles 1-2, in_ready=0 cycles 1-2, opB=0xC3 cycle 3, dstM=4,M=0xC3 cycle 4.
REQ-028 POP-style entry dstM=dstE=5, valE=0x11, mem_data=0x22 -> write port dstM=5,M=0x22; srcA=5 forwards 0x22 from MEM and WB.
REQ-029 srcA=0 with MEM.dstE=0 garbage, rf_A=0xFF -> opA=0x00; back-to-back ALU ops to reg 2 (0x01 then 0x02) -> opA=0x02 (MEM beats WB).
REQ-030 Assert rst while load waiting -> in_ready=1, stall=0, dstM=0 same cycle; mem_ack after release -> no write appears.
REQ-031 Continuous in_valid with ALU ops -> one transfer per cycle, in_ready never low.
